// File: rtl/vls_sp_arbiter.sv
// vls_sp_arbiter: two-lane (A/B) scratchpad access controller for the vector
// load/store unit. It accepts one request at a time and arbitrates between the
// lanes round-robin. It holds the scratchpad request until sp_gnt, waits for
// load data, and returns that data to the issuing lane with its vd tag.
//
// Build option:
//   VLS_ARB_FIXED_PRIO_EN  - lane A always wins ties; the priority pointer is
//                            tied to 0 (no round-robin state).
module vls_sp_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int VD_W   = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  // lane A
  input  logic              req_a_valid,
  output logic              req_a_ready,
  input  logic              req_a_wen,
  input  logic [ADDR_W-1:0] req_a_addr,
  input  logic [DATA_W-1:0] req_a_wdata,
  input  logic [VD_W-1:0]   req_a_vd,
  // lane B
  input  logic              req_b_valid,
  output logic              req_b_ready,
  input  logic              req_b_wen,
  input  logic [ADDR_W-1:0] req_b_addr,
  input  logic [DATA_W-1:0] req_b_wdata,
  input  logic [VD_W-1:0]   req_b_vd,
  // scratchpad port
  output logic              sp_req,
  output logic              sp_wen,
  output logic [ADDR_W-1:0] sp_addr,
  output logic [DATA_W-1:0] sp_wdata,
  input  logic              sp_gnt,
  input  logic              sp_rvalid,
  input  logic [DATA_W-1:0] sp_rdata,
  // load response
  output logic              rsp_a_valid,
  output logic              rsp_b_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic [VD_W-1:0]   rsp_vd,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;        // 0 = lane A, 1 = lane B
  logic                lat_wen_q, lat_wen_d;
  logic [ADDR_W-1:0]   lat_addr_q, lat_addr_d;
  logic [DATA_W-1:0]   lat_wdata_q, lat_wdata_d;
  logic [VD_W-1:0]     lat_vd_q, lat_vd_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic [VD_W-1:0]     rsp_vd_q, rsp_vd_d;
  logic                prio_q;                  // lane favoured on a tie
  logic                win_b;
  logic                accept;

  // Lane B wins if it is alone, or if both are valid and B holds priority.
  assign win_b  = req_b_valid & (~req_a_valid | prio_q);
  assign accept = (state_q == IDLE) & (req_a_valid | req_b_valid);

  assign req_a_ready = accept & ~win_b;
  assign req_b_ready = accept &  win_b;

`ifdef VLS_ARB_FIXED_PRIO_EN
  // Fixed priority: A always wins ties, so there is no pointer state.
  assign prio_q = 1'b0;
`else
  logic prio_d;

  // After each accept, the lane that lost gets priority on the next tie.
  always_comb begin
    prio_d = prio_q;
    if (accept) prio_d = ~win_b;
  end

  // Round-robin pointer register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) prio_q <= 1'b0;
    else       prio_q <= prio_d;
  end
`endif

  // Next-state logic, request latch and response capture.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    lat_wen_d   = lat_wen_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    lat_vd_d    = lat_vd_q;
    rsp_data_d  = rsp_data_q;
    rsp_vd_d    = rsp_vd_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d     = ISSUE;
          owner_d     = win_b;
          lat_wen_d   = win_b ? req_b_wen   : req_a_wen;
          lat_addr_d  = win_b ? req_b_addr  : req_a_addr;
          lat_wdata_d = win_b ? req_b_wdata : req_a_wdata;
          lat_vd_d    = win_b ? req_b_vd    : req_a_vd;
        end
      end
      ISSUE: begin
        // sp_rvalid only counts once the request has been granted.
        if (sp_gnt) begin
          if (lat_wen_q) begin
            state_d = IDLE;
          end else if (sp_rvalid) begin
            state_d    = RESP;
            rsp_data_d = sp_rdata;
            rsp_vd_d   = lat_vd_q;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (sp_rvalid) begin
          state_d    = RESP;
          rsp_data_d = sp_rdata;
          rsp_vd_d   = lat_vd_q;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, latch and response registers. Reset also aborts any transaction.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      lat_wen_q   <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      lat_vd_q    <= '0;
      rsp_data_q  <= '0;
      rsp_vd_q    <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      lat_wen_q   <= lat_wen_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
      lat_vd_q    <= lat_vd_d;
      rsp_data_q  <= rsp_data_d;
      rsp_vd_q    <= rsp_vd_d;
    end
  end

  // The request fields come straight from the latch, so they stay stable
  // for the whole of a grant stall.
  assign sp_req      = (state_q == ISSUE);
  assign sp_wen      = lat_wen_q;
  assign sp_addr     = lat_addr_q;
  assign sp_wdata    = lat_wdata_q;

  assign rsp_a_valid = (state_q == RESP) & ~owner_q;
  assign rsp_b_valid = (state_q == RESP) &  owner_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_vd      = rsp_vd_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_vls_sp_arbiter.sv
// Bench for vls_sp_arbiter. It has three parts:
//   - a directed vector table;
//   - hand-written grant-stall and mid-transaction reset sequences;
//   - a random run checked against a transaction-level reference model.
module tb_vls_sp_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int VW = 4;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic          req_a_valid, req_a_ready, req_a_wen;
  logic [AW-1:0] req_a_addr;
  logic [DW-1:0] req_a_wdata;
  logic [VW-1:0] req_a_vd;
  logic          req_b_valid, req_b_ready, req_b_wen;
  logic [AW-1:0] req_b_addr;
  logic [DW-1:0] req_b_wdata;
  logic [VW-1:0] req_b_vd;
  logic          sp_req, sp_wen, sp_gnt, sp_rvalid;
  logic [AW-1:0] sp_addr;
  logic [DW-1:0] sp_wdata, sp_rdata;
  logic          rsp_a_valid, rsp_b_valid, busy;
  logic [DW-1:0] rsp_data;
  logic [VW-1:0] rsp_vd;

  int n_pass  = 0;
  int n_total = 0;

  vls_sp_arbiter dut (
    .CLK(CLK), .nRST(nRST),
    .req_a_valid(req_a_valid), .req_a_ready(req_a_ready), .req_a_wen(req_a_wen),
    .req_a_addr(req_a_addr), .req_a_wdata(req_a_wdata), .req_a_vd(req_a_vd),
    .req_b_valid(req_b_valid), .req_b_ready(req_b_ready), .req_b_wen(req_b_wen),
    .req_b_addr(req_b_addr), .req_b_wdata(req_b_wdata), .req_b_vd(req_b_vd),
    .sp_req(sp_req), .sp_wen(sp_wen), .sp_addr(sp_addr), .sp_wdata(sp_wdata),
    .sp_gnt(sp_gnt), .sp_rvalid(sp_rvalid), .sp_rdata(sp_rdata),
    .rsp_a_valid(rsp_a_valid), .rsp_b_valid(rsp_b_valid),
    .rsp_data(rsp_data), .rsp_vd(rsp_vd), .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " req_a_ready"}, 32'(req_a_ready), 0);
    chk({tag, " req_b_ready"}, 32'(req_b_ready), 0);
    chk({tag, " sp_req"},      32'(sp_req), 0);
    chk({tag, " sp_wen"},      32'(sp_wen), 0);
    chk({tag, " sp_addr"},     32'(sp_addr), 0);
    chk({tag, " sp_wdata"},    32'(sp_wdata), 0);
    chk({tag, " rsp_a_valid"}, 32'(rsp_a_valid), 0);
    chk({tag, " rsp_b_valid"}, 32'(rsp_b_valid), 0);
    chk({tag, " rsp_data"},    32'(rsp_data), 0);
    chk({tag, " rsp_vd"},      32'(rsp_vd), 0);
    chk({tag, " busy"},        32'(busy), 0);
  endtask

  task automatic idle_inputs();
    req_a_valid = 0; req_a_wen = 0; req_a_addr = '0; req_a_wdata = '0; req_a_vd = '0;
    req_b_valid = 0; req_b_wen = 0; req_b_addr = '0; req_b_wdata = '0; req_b_vd = '0;
    sp_gnt = 0; sp_rvalid = 0; sp_rdata = '0;
  endtask

  task automatic next_cycle();
    @(posedge CLK); #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic av, aw; logic [15:0] aaddr; logic [3:0] avd;
    logic bv, bw; logic [15:0] baddr; logic [3:0] bvd;
    logic gnt, rv; logic [15:0] rdata;
    logic era, erb, ereq, ewen; logic [15:0] eaddr;
    logic erspa, erspb; logic [15:0] edata; logic [3:0] evd; logic ebusy;
  } vec_t;
  localparam int NV = 22;
  vec_t vecs [NV];

  // ---------------- random reference model ----------------
  typedef struct packed {
    logic wen; logic [15:0] addr; logic [15:0] wdata; logic [3:0] vd;
  } req_t;

  function automatic req_t rand_req();
    req_t r;
    r.wen   = 1'($urandom_range(0, 1));
    r.addr  = 16'($urandom);
    r.wdata = 16'($urandom);
    r.vd    = 4'($urandom);
    return r;
  endfunction

  req_t a_req, b_req, cur;
  logic a_pend, b_pend, rr_b;
  logic inflight, granted, resp_due, cur_lane, exp_wa, exp_wb;
  logic [15:0] last_data;
  logic [3:0]  last_vd;

  initial begin
    // ---------- reset values ----------
    idle_inputs();
    nRST = 0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk_zero("reset");
    next_cycle();
    nRST = 1;

    //             av aw aaddr      avd   bv bw baddr      bvd   gnt rv rdata      era erb req wen eaddr      rspa rspb edata      evd   busy
    vecs[0]  = '{H, H, 16'h0A00, 4'd0, H, H, 16'h0B00, 4'd0, L, L, 16'h0000, H, L, L, L, 16'h0000, L, L, 16'h0000, 4'd0, L};
    vecs[1]  = '{L, L, 16'h0000, 4'd0, H, H, 16'h0B00, 4'd0, H, L, 16'h0000, L, L, H, H, 16'h0A00, L, L, 16'h0000, 4'd0, H};
    vecs[2]  = '{L, L, 16'h0000, 4'd0, H, H, 16'h0B00, 4'd0, L, L, 16'h0000, L, H, L, L, 16'h0000, L, L, 16'h0000, 4'd0, L};
    vecs[3]  = '{L, L, 16'h0000, 4'd0, L, L, 16'h0000, 4'd0, H, L, 16'h0000, L, L, H, H, 16'h0B00, L, L, 16'h0000, 4'd0, H};
    vecs[4]  = '{L, L, 16'h0000, 4'd0, L, L, 16'h0000, 4'd0, L, L, 16'h0000, L, L, L, L, 16'h0000, L, L, 16'h0000, 4'd0, L};
    vecs[5]  = '{H, L, 16'h0C00, 4'd7, L, L, 16'h0000, 4'd0, L, L, 16'h0000, H, L, L, L, 16'h0000, L, L, 16'h0000, 4'd0, L};
    vecs[6]  = '{L, L, 16'h0000, 4'd0, L, L, 16'h0000, 4'd0, H, H, 16'h1111, L, L, H, L, 16'h0C00, L, L, 16'h0000, 4'd0, H};
    vecs[7]  = '{L, L, 16'h0000, 4'd0, L, L, 16'h0000, 4'd0, L, L, 16'h0000, L, L, L, L, 16'h0000, H, L, 16'h1111, 4'd7, H};
    vecs[8]  = '{L, L, 16'h0000, 4'd0, L, L, 16'h0000, 4'd0, L, L, 16'h0000, L, L, L, L, 16'h0000, L, L, 16'h1111, 4'd7, L};
    vecs[9]  = '{H, L, 16'h0040, 4'd3, L, L, 16'h0000, 4'd0, L, L, 16'h0000, H, L, L, L, 16'h0000, L, L, 16'h1111, 4'd7, L};
    vecs[10] = '{L, L, 16'h0000, 4'd0, L, L, 16'h0000, 4'd0, H, L, 16'h0000, L, L, H, L, 16'h0040, L, L, 16'h1111, 4'd7, H};
    vecs[11] = '{L, L, 16'h0000, 4'd0, L, L, 16'h0000, 4'd0, L, L, 16'h0000, L, L, L, L, 16'h0000, L, L, 16'h1111, 4'd7, H};
    vecs[12] = '{L, L, 16'h0000, 4'd0, L, L, 16'h0000, 4'd0, L, H, 16'hBEEF, L, L, L, L, 16'h0000, L, L, 16'h1111, 4'd7, H};
    vecs[13] = '{L, L, 16'h0000, 4'd0, L, L, 16'h0000, 4'd0, L, L, 16'h0000, L, L, L, L, 16'h0000, H, L, 16'hBEEF, 4'd3, H};
    vecs[14] = '{L, L, 16'h0000, 4'd0, L, L, 16'h0000, 4'd0, L, L, 16'h0000, L, L, L, L, 16'h0000, L, L, 16'hBEEF, 4'd3, L};
    vecs[15] = '{L, L, 16'h0000, 4'd0, L, L, 16'h0000, 4'd0, L, H, 16'hDEAD, L, L, L, L, 16'h0000, L, L, 16'hBEEF, 4'd3, L};
    vecs[16] = '{L, L, 16'h0000, 4'd0, L, L, 16'h0000, 4'd0, L, L, 16'h0000, L, L, L, L, 16'h0000, L, L, 16'hBEEF, 4'd3, L};
    vecs[17] = '{L, L, 16'h0000, 4'd0, H, L, 16'h0D00, 4'd9, L, L, 16'h0000, L, H, L, L, 16'h0000, L, L, 16'hBEEF, 4'd3, L};
    vecs[18] = '{L, L, 16'h0000, 4'd0, L, L, 16'h0000, 4'd0, H, L, 16'h0000, L, L, H, L, 16'h0D00, L, L, 16'hBEEF, 4'd3, H};
    vecs[19] = '{L, L, 16'h0000, 4'd0, L, L, 16'h0000, 4'd0, L, H, 16'h2222, L, L, L, L, 16'h0000, L, L, 16'hBEEF, 4'd3, H};
    vecs[20] = '{L, L, 16'h0000, 4'd0, L, L, 16'h0000, 4'd0, L, L, 16'h0000, L, L, L, L, 16'h0000, L, H, 16'h2222, 4'd9, H};
    vecs[21] = '{L, L, 16'h0000, 4'd0, L, L, 16'h0000, 4'd0, L, L, 16'h0000, L, L, L, L, 16'h0000, L, L, 16'h2222, 4'd9, L};

    for (int i = 0; i < NV; i++) begin
      req_a_valid = vecs[i].av; req_a_wen = vecs[i].aw; req_a_addr = vecs[i].aaddr;
      req_a_wdata = ~vecs[i].aaddr; req_a_vd = vecs[i].avd;
      req_b_valid = vecs[i].bv; req_b_wen = vecs[i].bw; req_b_addr = vecs[i].baddr;
      req_b_wdata = ~vecs[i].baddr; req_b_vd = vecs[i].bvd;
      sp_gnt = vecs[i].gnt; sp_rvalid = vecs[i].rv; sp_rdata = vecs[i].rdata;
      @(negedge CLK);
      chk($sformatf("v%0d req_a_ready", i), 32'(req_a_ready), 32'(vecs[i].era));
      chk($sformatf("v%0d req_b_ready", i), 32'(req_b_ready), 32'(vecs[i].erb));
      chk($sformatf("v%0d sp_req", i),      32'(sp_req),      32'(vecs[i].ereq));
      if (vecs[i].ereq) begin
        chk($sformatf("v%0d sp_addr", i), 32'(sp_addr), 32'(vecs[i].eaddr));
        chk($sformatf("v%0d sp_wen", i),  32'(sp_wen),  32'(vecs[i].ewen));
      end
      chk($sformatf("v%0d rsp_a_valid", i), 32'(rsp_a_valid), 32'(vecs[i].erspa));
      chk($sformatf("v%0d rsp_b_valid", i), 32'(rsp_b_valid), 32'(vecs[i].erspb));
      chk($sformatf("v%0d rsp_data", i),    32'(rsp_data),    32'(vecs[i].edata));
      chk($sformatf("v%0d rsp_vd", i),      32'(rsp_vd),      32'(vecs[i].evd));
      chk($sformatf("v%0d busy", i),        32'(busy),        32'(vecs[i].ebusy));
      next_cycle();
    end

    // ---------- grant stall: lane B store, 5 cycles without sp_gnt ----------
    idle_inputs();
    req_b_valid = 1; req_b_wen = 1; req_b_addr = 16'h1234; req_b_wdata = 16'h00FF; req_b_vd = 4'd2;
    @(negedge CLK);
    chk("stall accept b", 32'(req_b_ready), 1);
    next_cycle();
    // Both lanes present new requests during the stall; neither may be accepted.
    req_a_valid = 1; req_a_addr = 16'h5555; req_b_addr = 16'h6666; req_b_wdata = 16'h7777;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      chk($sformatf("stall%0d sp_req", c),   32'(sp_req), 1);
      chk($sformatf("stall%0d sp_addr", c),  32'(sp_addr), 32'h1234);
      chk($sformatf("stall%0d sp_wdata", c), 32'(sp_wdata), 32'h00FF);
      chk($sformatf("stall%0d sp_wen", c),   32'(sp_wen), 1);
      chk($sformatf("stall%0d ready_a", c),  32'(req_a_ready), 0);
      chk($sformatf("stall%0d ready_b", c),  32'(req_b_ready), 0);
      next_cycle();
    end
    idle_inputs();
    sp_gnt = 1;
    @(negedge CLK);
    chk("stall gnt sp_req", 32'(sp_req), 1);
    next_cycle();
    sp_gnt = 0;
    @(negedge CLK);
    chk("stall done busy", 32'(busy), 0);
    chk("stall done sp_req", 32'(sp_req), 0);
    next_cycle();

    // ---------- reset while in WAIT ----------
    req_a_valid = 1; req_a_wen = 0; req_a_addr = 16'h0777; req_a_vd = 4'd5;
    @(negedge CLK);
    chk("wrst accept a", 32'(req_a_ready), 1);
    next_cycle();
    req_a_valid = 0; sp_gnt = 1;
    @(negedge CLK);
    chk("wrst sp_req", 32'(sp_req), 1);
    next_cycle();
    sp_gnt = 0;
    @(negedge CLK);
    chk("wrst wait busy", 32'(busy), 1);
    #1 nRST = 0;
    #1 chk_zero("midreset");
    next_cycle();
    nRST = 1;
    sp_rvalid = 1; sp_rdata = 16'h3333;
    @(negedge CLK);
    chk("post-rst stray rsp_a", 32'(rsp_a_valid), 0);
    chk("post-rst stray busy", 32'(busy), 0);
    next_cycle();
    sp_rvalid = 0;
    @(negedge CLK);
    chk("post-rst rsp_a", 32'(rsp_a_valid), 0);
    chk("post-rst rsp_data", 32'(rsp_data), 0);
    next_cycle();
    // Before reset, A had just won; after reset the pointer is back at A.
    req_a_valid = 1; req_a_wen = 1; req_a_addr = 16'h0AAA;
    req_b_valid = 1; req_b_wen = 1; req_b_addr = 16'h0BBB;
    @(negedge CLK);
    chk("post-rst ready_a", 32'(req_a_ready), 1);
    chk("post-rst ready_b", 32'(req_b_ready), 0);
    next_cycle();
    idle_inputs();
    sp_gnt = 1;
    @(negedge CLK);
    chk("post-rst sp_addr", 32'(sp_addr), 32'h0AAA);
    next_cycle();
    sp_gnt = 0;

    // ---------- random run against the reference model ----------
    nRST = 0;
    next_cycle();
    nRST = 1;
    a_pend = 0; b_pend = 0; rr_b = 0;
    inflight = 0; granted = 0; resp_due = 0; cur_lane = 0;
    cur = '0; a_req = '0; b_req = '0;
    last_data = '0; last_vd = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!a_pend && $urandom_range(0, 2) == 0) begin a_pend = 1; a_req = rand_req(); end
      if (!b_pend && $urandom_range(0, 2) == 0) begin b_pend = 1; b_req = rand_req(); end
      req_a_valid = a_pend; req_a_wen = a_req.wen; req_a_addr = a_req.addr;
      req_a_wdata = a_req.wdata; req_a_vd = a_req.vd;
      req_b_valid = b_pend; req_b_wen = b_req.wen; req_b_addr = b_req.addr;
      req_b_wdata = b_req.wdata; req_b_vd = b_req.vd;
      sp_gnt    = 1'($urandom_range(0, 1));
      sp_rvalid = ($urandom_range(0, 2) == 0);
      sp_rdata  = 16'($urandom);
      @(negedge CLK);

      exp_wa = !inflight && a_pend && (!b_pend || !rr_b);
      exp_wb = !inflight && b_pend && (!a_pend ||  rr_b);
      chk("rnd req_a_ready", 32'(req_a_ready), 32'(exp_wa));
      chk("rnd req_b_ready", 32'(req_b_ready), 32'(exp_wb));
      chk("rnd sp_req", 32'(sp_req), 32'(inflight && !granted && !resp_due));
      if (inflight && !granted && !resp_due) begin
        chk("rnd sp_addr",  32'(sp_addr),  32'(cur.addr));
        chk("rnd sp_wdata", 32'(sp_wdata), 32'(cur.wdata));
        chk("rnd sp_wen",   32'(sp_wen),   32'(cur.wen));
      end
      chk("rnd rsp_a_valid", 32'(rsp_a_valid), 32'(resp_due && !cur_lane));
      chk("rnd rsp_b_valid", 32'(rsp_b_valid), 32'(resp_due &&  cur_lane));
      chk("rnd rsp_data", 32'(rsp_data), 32'(last_data));
      chk("rnd rsp_vd",   32'(rsp_vd),   32'(last_vd));
      chk("rnd busy",     32'(busy),     32'(inflight));

      // Advance the transaction model to what the coming edge should do.
      if (!inflight) begin
        if (exp_wa || exp_wb) begin
          cur      = exp_wa ? a_req : b_req;
          cur_lane = exp_wb;
          inflight = 1; granted = 0; resp_due = 0;
          if (exp_wa) a_pend = 0; else b_pend = 0;
`ifdef VLS_ARB_FIXED_PRIO_EN
          rr_b = 1'b0;
`else
          rr_b = exp_wa;
`endif
        end
      end else if (resp_due) begin
        inflight = 0; resp_due = 0;
      end else if (!granted) begin
        if (sp_gnt) begin
          if (cur.wen) inflight = 0;
          else begin
            granted = 1;
            if (sp_rvalid) begin resp_due = 1; last_data = sp_rdata; last_vd = cur.vd; end
          end
        end
      end else if (sp_rvalid) begin
        resp_due = 1; last_data = sp_rdata; last_vd = cur.vd;
      end
      next_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
